// File: rtl/cache_control_pkg.sv
// Shared types for the L1 cache controller.
// Holds the controller state encoding.
package cache_control_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_perf_counters.sv
// Three saturating event counters for the cache controller.
// Counts hits, misses and dirty writebacks; each sticks at all-ones.
module cache_perf_counters #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit_inc,
    input  logic              miss_inc,
    input  logic              wb_inc,
    output logic [PERF_W-1:0] perf_hits,
    output logic [PERF_W-1:0] perf_misses,
    output logic [PERF_W-1:0] perf_wbacks
);

    logic [PERF_W-1:0] hits_q, hits_d;
    logic [PERF_W-1:0] misses_q, misses_d;
    logic [PERF_W-1:0] wbacks_q, wbacks_d;

    // Increment on each event unless already saturated.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        wbacks_d = wbacks_q;
        if (hit_inc && (hits_q != '1))
            hits_d = hits_q + 1'b1;
        if (miss_inc && (misses_q != '1))
            misses_d = misses_q + 1'b1;
        if (wb_inc && (wbacks_q != '1))
            wbacks_d = wbacks_q + 1'b1;
    end

    // Counter state, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            wbacks_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
            wbacks_q <= wbacks_d;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
    assign perf_wbacks = wbacks_q;

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back, write-allocate L1 cache.
// Optional perf counters enabled by defining CACHE_PERF_CNT_EN.
module cache_control
    import cache_control_pkg::*;
`ifdef CACHE_PERF_CNT_EN
#(
    parameter int PERF_W = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic mem_read,
    input  logic mem_write,
    input  logic tag_match,
    input  logic whichtag,
    input  logic valid,
    input  logic dirty,
    input  logic lru_out,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic write0,
    output logic write1,
    output logic wdirty0,
    output logic wdirty1,
    output logic dirty0_val,
    output logic dirty1_val,
    output logic inrw1,
    output logic inw1
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_hits,
    output logic [PERF_W-1:0] perf_misses,
    output logic [PERF_W-1:0] perf_wbacks
`endif
);

    cache_state_t state_q, state_d;
    logic         hit;
    logic         req;

    assign hit = tag_match & valid;
    assign req = mem_read | mem_write;

    // Next state and all strobes; a fill always lands in the LRU way clean.
    always_comb begin
        state_d    = state_q;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        write0     = 1'b0;
        write1     = 1'b0;
        wdirty0    = 1'b0;
        wdirty1    = 1'b0;
        dirty0_val = 1'b0;
        dirty1_val = 1'b0;
        inrw1      = 1'b0;
        inw1       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    inrw1    = 1'b1;
                    if (mem_write) begin
                        inw1 = 1'b1;
                        if (whichtag) begin
                            write1     = 1'b1;
                            wdirty1    = 1'b1;
                            dirty1_val = 1'b1;
                        end else begin
                            write0     = 1'b1;
                            wdirty0    = 1'b1;
                            dirty0_val = 1'b1;
                        end
                    end
                end else if (req) begin
                    state_d = dirty ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                if (pmem_resp)
                    state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    if (lru_out) begin
                        write1  = 1'b1;
                        wdirty1 = 1'b1;
                    end else begin
                        write0  = 1'b1;
                        wdirty0 = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any outstanding memory request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

`ifdef CACHE_PERF_CNT_EN
    logic miss_inc;
    logic wb_inc;

    assign miss_inc = (state_q == IDLE) && (state_d != IDLE);
    assign wb_inc   = (state_q == WRITEBACK) && pmem_resp;

    cache_perf_counters #(
        .PERF_W(PERF_W)
    ) u_perf (
        .clk        (clk),
        .reset      (reset),
        .hit_inc    (mem_resp),
        .miss_inc   (miss_inc),
        .wb_inc     (wb_inc),
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses),
        .perf_wbacks(perf_wbacks)
    );
`endif

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control.
// Datapath inputs are driven directly; expected strobes queued per cycle.
module tb_cache_control;

    localparam logic [10:0] MR = 11'h400;
    localparam logic [10:0] PR = 11'h200;
    localparam logic [10:0] PW = 11'h100;
    localparam logic [10:0] W0 = 11'h080;
    localparam logic [10:0] W1 = 11'h040;
    localparam logic [10:0] D0 = 11'h020;
    localparam logic [10:0] D1 = 11'h010;
    localparam logic [10:0] V0 = 11'h008;
    localparam logic [10:0] V1 = 11'h004;
    localparam logic [10:0] LR = 11'h002;
    localparam logic [10:0] IW = 11'h001;
    localparam logic [10:0] Z  = 11'h000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0;
    logic tag_match = 1'b0, whichtag = 1'b0, valid = 1'b0;
    logic dirty = 1'b0, lru_out = 1'b0, pmem_resp = 1'b0;
    logic mem_resp, pmem_read, pmem_write;
    logic write0, write1, wdirty0, wdirty1;
    logic dirty0_val, dirty1_val, inrw1, inw1;
    logic [10:0] outs;

`ifdef CACHE_PERF_CNT_EN
    localparam int PCW = 4;
    logic [PCW-1:0] perf_hits, perf_misses, perf_wbacks;
`endif

    int errors = 0;
    int checks = 0;
    int m_hits = 0, m_miss = 0, m_wb = 0;
    logic [10:0] expq[$];
    string       namq[$];

    always #5 clk = ~clk;

    assign outs = {mem_resp, pmem_read, pmem_write, write0, write1,
                   wdirty0, wdirty1, dirty0_val, dirty1_val,
                   inrw1, inw1};

`ifdef CACHE_PERF_CNT_EN
    cache_control #(.PERF_W(PCW)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .tag_match  (tag_match),
        .whichtag   (whichtag),
        .valid      (valid),
        .dirty      (dirty),
        .lru_out    (lru_out),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .write0     (write0),
        .write1     (write1),
        .wdirty0    (wdirty0),
        .wdirty1    (wdirty1),
        .dirty0_val (dirty0_val),
        .dirty1_val (dirty1_val),
        .inrw1      (inrw1),
        .inw1       (inw1),
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses),
        .perf_wbacks(perf_wbacks)
    );
`else
    cache_control dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .tag_match (tag_match),
        .whichtag  (whichtag),
        .valid     (valid),
        .dirty     (dirty),
        .lru_out   (lru_out),
        .pmem_resp (pmem_resp),
        .mem_resp  (mem_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .write0    (write0),
        .write1    (write1),
        .wdirty0   (wdirty0),
        .wdirty1   (wdirty1),
        .dirty0_val(dirty0_val),
        .dirty1_val(dirty1_val),
        .inrw1     (inrw1),
        .inw1      (inw1)
    );
`endif

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            logic [10:0] e;
            string       n;
            e = expq.pop_front();
            n = namq.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", n, outs, e);
            end
            if (pmem_read && pmem_write) begin
                errors++;
                $display("FAIL %s pmem_read and pmem_write both high", n);
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    task automatic cyc(input string n,
                       input logic rd, input logic wr,
                       input logic tm, input logic wt,
                       input logic v, input logic d,
                       input logic lru, input logic pr,
                       input logic [10:0] exp);
        mem_read  = rd;
        mem_write = wr;
        tag_match = tm;
        whichtag  = wt;
        valid     = v;
        dirty     = d;
        lru_out   = lru;
        pmem_resp = pr;
        expq.push_back(exp);
        namq.push_back(n);
        if ((exp & MR) != Z)
            m_hits++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {21'd0, outs}, 32'd0);
`ifdef CACHE_PERF_CNT_EN
        chk("reset_perf_hits", {28'd0, perf_hits}, 32'd0);
`endif
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, Z);

        cyc("t1_miss", 1, 0, 0, 0, 0, 0, 0, 0, Z);
        cyc("t1_fill", 1, 0, 0, 0, 0, 0, 0, 0, PR);
        reset = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        chk("t1_reset_outs", {21'd0, outs}, 32'd0);
        m_hits = 0;
        m_miss = 0;
        m_wb = 0;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        cyc("t1_late_resp", 0, 0, 0, 0, 0, 0, 0, 1, Z);
        cyc("t1_idle", 0, 0, 0, 0, 0, 0, 0, 0, Z);

        cyc("t2_miss", 1, 0, 0, 0, 0, 0, 1, 0, Z);
        m_miss++;
        cyc("t2_fill_wait", 1, 0, 0, 0, 0, 0, 1, 0, PR);
        cyc("t2_fill_done", 1, 0, 0, 0, 0, 0, 1, 1, PR | W1 | D1);
        cyc("t2_hit", 1, 0, 1, 1, 1, 0, 0, 0, MR | LR);
        cyc("t2_gap", 0, 0, 0, 0, 0, 0, 0, 0, Z);
        cyc("t2_hit2", 1, 0, 1, 1, 1, 0, 0, 0, MR | LR);

        cyc("t3_wr_hit1", 0, 1, 1, 1, 1, 0, 0, 0,
            MR | LR | IW | W1 | D1 | V1);
        cyc("t3_wr_hit0", 0, 1, 1, 0, 1, 0, 1, 0,
            MR | LR | IW | W0 | D0 | V0);

        cyc("t3_invalid", 1, 0, 1, 0, 0, 0, 0, 0, Z);
        m_miss++;
        cyc("t3_fill", 1, 0, 1, 0, 0, 0, 0, 1, PR | W0 | D0);
        cyc("t3_hit", 1, 0, 1, 0, 1, 0, 1, 0, MR | LR);

        cyc("t4_miss", 1, 0, 0, 0, 0, 1, 0, 0, Z);
        m_miss++;
        cyc("t4_wb", 1, 0, 0, 0, 0, 1, 0, 0, PW);
        cyc("t4_wb2", 1, 0, 0, 0, 0, 1, 0, 0, PW);
        cyc("t4_wb_done", 1, 0, 0, 0, 0, 1, 0, 1, PW);
        m_wb++;
        cyc("t4_fill", 1, 0, 0, 0, 0, 1, 0, 0, PR);
        cyc("t4_fill_done", 1, 0, 0, 0, 0, 0, 0, 1, PR | W0 | D0);
        cyc("t4_hit", 1, 0, 1, 0, 1, 0, 1, 0, MR | LR);

        cyc("t4w_miss", 0, 1, 0, 0, 0, 1, 1, 0, Z);
        m_miss++;
        cyc("t4w_wb_done", 0, 1, 0, 0, 0, 1, 1, 1, PW);
        m_wb++;
        cyc("t4w_fill_done", 0, 1, 0, 0, 0, 0, 1, 1, PR | W1 | D1);
        cyc("t4w_hit", 0, 1, 1, 1, 1, 0, 0, 0,
            MR | LR | IW | W1 | D1 | V1);

        for (int i = 0; i < 20; i++) begin
            logic wt;
            wt = i[0];
            cyc("t5_hit", 1, 0, 1, wt, 1, 0, ~wt, 0, MR | LR);
        end
        cyc("t5_miss", 1, 0, 0, 0, 0, 0, 1, 0, Z);
        m_miss++;
        cyc("t5_fill_done", 1, 0, 0, 0, 0, 0, 1, 1, PR | W1 | D1);
        cyc("t5_hit", 1, 0, 1, 1, 1, 0, 0, 0, MR | LR);

        cyc("drop_miss", 1, 0, 0, 0, 0, 0, 0, 0, Z);
        m_miss++;
        cyc("drop_fill", 0, 0, 0, 0, 0, 0, 0, 0, PR);
        cyc("drop_done", 0, 0, 0, 0, 0, 0, 0, 1, PR | W0 | D0);
        cyc("drop_idle", 0, 0, 0, 0, 0, 0, 0, 0, Z);

        for (int k = 0; k < 5 && expq.size() > 0; k++)
            @(posedge clk);
        chk("queue_drained", expq.size(), 32'd0);

`ifdef CACHE_PERF_CNT_EN
        @(negedge clk);
        chk("perf_hits",
            {28'd0, perf_hits},
            (m_hits > 15) ? 32'd15 : m_hits);
        chk("perf_misses",
            {28'd0, perf_misses},
            (m_miss > 15) ? 32'd15 : m_miss);
        chk("perf_wbacks",
            {28'd0, perf_wbacks},
            (m_wb > 15) ? 32'd15 : m_wb);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
